cond_issue_ctrl: RTL and testbench
==================================

# cond_issue_ctrl

Conditional-execution and issue controller for the ID stage of the ARM pipeline. It owns the architectural NZCV status register and evaluates each decoded instruction's 4-bit condition field against it. Each instruction is then issued, cancelled (turned into a bubble) or stalled. The block also tracks in-flight flag writes from EXE and sequences the IF/ID squash after a taken branch.

## Interface
- FLUSH_CYCLES, 2, number of consecutive cycles `flush` is held after a taken branch issues (legal range 1..7)
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_cond  in  4  condition field [31:28] of the ID instruction
- id_s  in  1  ID instruction writes flags (S bit)
- id_needs_c  in  1  ID instruction reads C as ALU carry-in (ADC/SBC/RSC)
- id_branch  in  1  ID instruction is B/BL
- exe_flags_valid  in  1  EXE presents flags of a flag-setting instruction this cycle
- exe_flags  in  4  NZCV from the ALU, {N,Z,C,V}
- mem_stall  in  1  global freeze from the memory stage
- status_reg  out  4  architectural {N,Z,C,V}; reset 4'b0000
- issue  out  1  ID instruction advances to EXE with effects enabled; reset 0
- cancel  out  1  ID instruction advances as a bubble (condition failed); reset 0
- stall_id  out  1  hold IF and ID; reset 0
- flush  out  1  squash IF/ID contents; reset 0
- branch_taken  out  1  issued instruction is a taken branch; reset 0

## Operation
- Condition semantics (ARM): EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); 1110 and 1111 always true.
- Flag dependency: `dep = id_valid & (id_cond < 4'b1110 | id_needs_c)`.
- `pending` bit: set on the edge where an instruction with `id_s` issues. Cleared on the edge where `exe_flags_valid` is high, unless a new S instruction issues in the same cycle, in which case it stays set.
- `stall_id = id_valid & dep & pending & state==RUN`, OR `mem_stall`.
- When not stalled and `state==RUN` and `id_valid`:
  - If the condition is true, `issue=1`.
  - If the condition is false, `cancel=1`. A cancelled instruction never sets `pending` and never flushes.
- `branch_taken = issue & id_branch`.
- status_reg update: loads `exe_flags` on the edge where `exe_flags_valid & !mem_stall`. It is otherwise held.
- The condition is always evaluated against the registered `status_reg`. There is no forwarding; dependency is resolved by the one-cycle stall.
- FSM states:
  - RUN: on `branch_taken`, go to FLUSH with counter loaded to FLUSH_CYCLES-1. If FLUSH_CYCLES==1, stay in RUN.
  - FLUSH: counter decrements each non-stalled cycle. Return to RUN when it reaches 0 and decrements. `id_valid` is ignored here; `issue`, `cancel` and `stall_id` (except from mem_stall) are 0.
- `flush = branch_taken | state==FLUSH`.
- `mem_stall` behaviour:
  - Forces `issue`, `cancel` and `branch_taken` to 0.
  - Freezes `pending`, the counter, the FSM and `status_reg`.
  - `flush` keeps its current value.

## Timing
- All outputs are combinational from registered state plus ID inputs; the decision is made in the same cycle the instruction sits in ID.
- A flag-dependent instruction directly behind an S instruction stalls exactly 1 cycle, assuming EXE asserts `exe_flags_valid` the cycle after issue.
- A taken branch holds `flush` high for FLUSH_CYCLES cycles, starting in the issue cycle; the first instruction is accepted in the following cycle.
- Reset asserted at any point, including mid-FLUSH or with pending set: the block returns immediately to RUN, counter 0, pending 0, status 0, and all outputs 0.

## Structure
- Shared package `arm_cond_pkg`:
  - COND_* localparams (EQ..AL, NV).
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FSM state enum {RUN, FLUSH}.
- Sub-module `cond_eval`: purely combinational (cond, nzcv) -> pass. It is also reused by the verification model.
- Top level holds the status register, the `pending` flop, the FSM and the flush counter.

## Test plan
- Reset, then id_valid, cond=0000 (EQ): cancel=1, issue=0. Same instruction with cond=0001 (NE): issue=1.
- Issue SUBS with id_s=1. Next cycle EXE supplies exe_flags=4'b0100 and ID holds BEQ. Required: stall_id=1 for 1 cycle, then issue=1, branch_taken=1, flush=1 for 2 cycles, status_reg=0100.
- Sweep all 16 cond codes across all 16 NZCV values loaded via exe_flags: issue/cancel must match the ARM table, with 1111 always issuing.
- Hold mem_stall=1 for 3 cycles mid-FLUSH with exe_flags_valid=1: counter, status_reg and pending are unchanged, and flush stays high.
- Cancelled branch with S=1 (cond fails): no flush, pending stays 0, and the next flag-dependent instruction issues without a stall.
- Assert rst=0 mid-FLUSH with pending=1: all outputs are 0 immediately. After release, an AL instruction issues on the first valid cycle.

Source files
------------

// File: rtl/arm_cond_pkg.sv
// Shared definitions for ARM condition evaluation and the ID issue controller.
package arm_cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator: (cond, nzcv) -> pass.
module cond_eval
  import arm_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  // Decode the condition field against the supplied flags.
  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_issue_ctrl.sv
// ID-stage conditional issue controller: NZCV register, flag-dependency stall,
// issue/cancel decision and post-branch flush sequencing.
module cond_issue_ctrl
  import arm_cond_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       id_s,
  input  logic       id_needs_c,
  input  logic       id_branch,
  input  logic       exe_flags_valid,
  input  logic [3:0] exe_flags,
  input  logic       mem_stall,
  output logic [3:0] status_reg,
  output logic       issue,
  output logic       cancel,
  output logic       stall_id,
  output logic       flush,
  output logic       branch_taken
);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       pending, pending_nxt;
  logic [3:0] status_nxt;
  logic       pass, dep, go;

  cond_eval u_cond_eval (
    .cond (id_cond),
    .nzcv (status_reg),
    .pass (pass)
  );

  // Issue decision; outputs are gated by rst so they drop the moment reset asserts.
  always_comb begin
    dep          = id_valid & ((id_cond < COND_AL) | id_needs_c);
    stall_id     = rst & ((dep & pending & (state == RUN)) | mem_stall);
    go           = rst & (state == RUN) & id_valid & ~stall_id;
    issue        = go & pass;
    cancel       = go & ~pass;
    branch_taken = issue & id_branch;
    flush        = rst & (branch_taken | (state == FLUSH));
  end

  // Next-state for FSM, flush counter, pending flag and status register.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    status_nxt  = status_reg;
    if (!mem_stall) begin
      if (exe_flags_valid)
        status_nxt = exe_flags;
      if (issue && id_s)
        pending_nxt = 1'b1;
      else if (exe_flags_valid)
        pending_nxt = 1'b0;
      case (state)
        RUN: begin
          if (branch_taken && (FLUSH_CYCLES > 1)) begin
            state_nxt = FLUSH;
            cnt_nxt   = 3'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          // The issue cycle already counted as one flush cycle, so the state
          // is left as the counter steps from 1 down to 0.
          cnt_nxt = cnt - 3'd1;
          if (cnt <= 3'd1) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      cnt        <= '0;
      pending    <= 1'b0;
      status_reg <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pending    <= pending_nxt;
      status_reg <= status_nxt;
    end
  end

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Directed self-checking bench for cond_issue_ctrl.
module tb_cond_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_s, id_needs_c, id_branch;
  logic [3:0] id_cond;
  logic       exe_flags_valid, mem_stall;
  logic [3:0] exe_flags;
  logic [3:0] status_reg;
  logic       issue, cancel, stall_id, flush, branch_taken;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  cond_issue_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_cond         (id_cond),
    .id_s            (id_s),
    .id_needs_c      (id_needs_c),
    .id_branch       (id_branch),
    .exe_flags_valid (exe_flags_valid),
    .exe_flags       (exe_flags),
    .mem_stall       (mem_stall),
    .status_reg      (status_reg),
    .issue           (issue),
    .cancel          (cancel),
    .stall_id        (stall_id),
    .flush           (flush),
    .branch_taken    (branch_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ARM condition table.
  function automatic logic arm_cond(input logic [3:0] c, input logic [3:0] f);
    logic fn, fz, fc, fv;
    fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
    case (c)
      4'd0:    return fz;
      4'd1:    return !fz;
      4'd2:    return fc;
      4'd3:    return !fc;
      4'd4:    return fn;
      4'd5:    return !fn;
      4'd6:    return fv;
      4'd7:    return !fv;
      4'd8:    return fc && !fz;
      4'd9:    return !fc || fz;
      4'd10:   return fn == fv;
      4'd11:   return fn != fv;
      4'd12:   return !fz && (fn == fv);
      4'd13:   return fz || (fn != fv);
      default: return 1'b1;
    endcase
  endfunction

  task automatic set_id(input logic v, input logic [3:0] c, input logic s,
                        input logic nc, input logic br);
    id_valid = v; id_cond = c; id_s = s; id_needs_c = nc; id_branch = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Compact check of the five control outputs {issue,cancel,stall_id,flush,branch_taken}.
  task automatic check_ctl(input string tag, input logic [4:0] exp);
    check(tag, {3'b0, issue, cancel, stall_id, flush, branch_taken}, {3'b0, exp});
  endtask

  initial begin
    rst = 1'b0;
    exe_flags_valid = 1'b0; exe_flags = '0; mem_stall = 1'b0;
    set_id(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    #12;
    check_ctl("reset_ctl", 5'b00000);
    check("reset_status", {4'b0, status_reg}, 8'h00);
    rst = 1'b1;
    tick();

    // EQ fails with Z=0, NE passes.
    set_id(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    check_ctl("eq_cancel", 5'b01000);
    set_id(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    check_ctl("ne_issue", 5'b10000);
    tick();

    // SUBS then dependent BEQ: one stall cycle, then taken branch with 2-cycle flush.
    set_id(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0);
    check_ctl("subs_issue", 5'b10000);
    tick();
    exe_flags_valid = 1'b1; exe_flags = 4'b0100;
    set_id(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    check_ctl("beq_stall", 5'b00100);
    tick();
    exe_flags_valid = 1'b0;
    #1;
    check("status_0100", {4'b0, status_reg}, 8'h04);
    check_ctl("beq_taken", 5'b10011);
    tick();
    set_id(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0);
    check_ctl("flush_cycle2", 5'b00010);
    tick();
    check_ctl("after_flush", 5'b10000);
    tick();

    // Taken branch with S, then mem_stall held 3 cycles inside FLUSH.
    set_id(1'b1, 4'b1110, 1'b1, 1'b0, 1'b1);
    check_ctl("bs_taken", 5'b10011);
    tick();
    set_id(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0);
    mem_stall = 1'b1; exe_flags_valid = 1'b1; exe_flags = 4'b1111;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_ctl("mstall_ctl", 5'b00110);
      tick();
      check("mstall_status", {4'b0, status_reg}, 8'h04);
    end
    mem_stall = 1'b0; exe_flags_valid = 1'b0;
    #1;
    check_ctl("post_mstall_flush", 5'b00010);
    tick();
    set_id(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    check_ctl("pending_held", 5'b00100);
    exe_flags_valid = 1'b1; exe_flags = 4'b0100;
    tick();
    exe_flags_valid = 1'b0;
    #1;
    check_ctl("eq_after_clear", 5'b10000);
    tick();

    // Cancelled flag-setting branch: no flush, no pending.
    set_id(1'b1, 4'b0001, 1'b1, 1'b0, 1'b1);
    check_ctl("cancel_branch", 5'b01000);
    tick();
    set_id(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    check_ctl("no_stall_after_cancel", 5'b10000);
    tick();

    // Reset asserted mid-FLUSH with pending set.
    set_id(1'b1, 4'b1110, 1'b1, 1'b0, 1'b1);
    check_ctl("rst_pre_branch", 5'b10011);
    tick();
    set_id(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0);
    check_ctl("rst_pre_flush", 5'b00010);
    rst = 1'b0;
    #1;
    check_ctl("rst_mid_flush", 5'b00000);
    check("rst_mid_status", {4'b0, status_reg}, 8'h00);
    #1;
    rst = 1'b1;
    #1;
    check_ctl("rst_release_al", 5'b10000);
    tick();

    // Sweep all conditions over all flag values.
    for (int f = 0; f < 16; f++) begin
      set_id(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      exe_flags_valid = 1'b1; exe_flags = 4'(f);
      tick();
      exe_flags_valid = 1'b0;
      check("sweep_status", {4'b0, status_reg}, 8'(f));
      for (int c = 0; c < 16; c++) begin
        set_id(1'b1, 4'(c), 1'b0, 1'b0, 1'b0);
        check("sweep_issue", {7'b0, issue}, {7'b0, arm_cond(4'(c), 4'(f))});
        check("sweep_cancel", {7'b0, cancel}, {7'b0, !arm_cond(4'(c), 4'(f))});
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
